// File: rtl/fmeasure_reader.sv
// Frequency-meter reader: requests a measurement, captures the two counts
// and streams out REF_HZ * cb / ca from a 64/32 restoring divider.
module fmeasure_reader #(
    parameter int unsigned REF_HZ       = 100000000,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        trigger,
    output logic        meas_start,
    input  logic        meas_busy,
    input  logic [31:0] meas_ca,
    input  logic [31:0] meas_cb,
    output logic [31:0] freq,
    output logic        freq_valid,
    input  logic        freq_ready,
    output logic        err,
    output logic        idle
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_DONE, CAPTURE, DIV, OUT
    } state_t;

    localparam logic [63:0] REF64    = 64'(REF_HZ);
    localparam logic [6:0]  TMO_LAST = 7'(BUSY_TIMEOUT - 1);
    localparam logic [6:0]  DIV_LAST = 7'd64;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] freq_q, freq_d;
    logic [31:0] ca_q, ca_d;
    logic [31:0] cb_q, cb_d;
    logic [63:0] num_q, num_d;
    logic [32:0] rem_q, rem_d;
    logic [6:0]  cnt_q, cnt_d;

    // One restoring step; num shifts out dividend bits and takes quotient bits.
    logic [32:0] rem_sh;
    logic [32:0] den33;
    logic        ge;
    logic [32:0] rem_nx;

    always_comb begin
        rem_sh = {rem_q[31:0], num_q[63]};
        den33  = {1'b0, ca_q};
        ge     = rem_q[32] | (rem_sh >= den33);
        rem_nx = ge ? (rem_sh - den33) : rem_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            freq_q  <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            freq_q  <= freq_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        valid_d = valid_q;
        err_d   = err_q;
        freq_d  = freq_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        num_d   = num_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trigger || enable) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (meas_busy) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    start_d = 1'b0;
                    freq_d  = '1;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            WAIT_DONE: begin
                if (!meas_busy) begin
                    ca_d    = meas_ca;
                    cb_d    = meas_cb;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Counts with bit31 set came from a signed-int meter: invalid.
                if (ca_q == '0 || ca_q[31] || cb_q[31]) begin
                    freq_d  = '1;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    num_d   = REF64 * {32'd0, cb_q};
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (cnt_q == DIV_LAST) begin
                    if (|num_q[63:32]) begin
                        freq_d = '1;
                        err_d  = 1'b1;
                    end else begin
                        freq_d = num_q[31:0];
                        err_d  = 1'b0;
                    end
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    rem_d = rem_nx;
                    num_d = {num_q[62:0], ge};
                    cnt_d = cnt_q + 7'd1;
                end
            end
            OUT: begin
                if (freq_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign meas_start = start_q;
    assign freq       = freq_q;
    assign freq_valid = valid_q;
    assign err        = err_q;
    assign idle       = (state_q == IDLE);

endmodule
